hr_local_inject: RTL

- Injection-side network interface for one local port of a hierarchical-ring node.
- Accepts flits from the attached core over a valid/ready handshake and buffers them in a small FIFO.
- Offers the FIFO head on the node's local input port and holds it until the node acks, retrying on deflection/denial.
- Flags injection starvation so the core can throttle; one instance per local port.

---
 rtl/hr_local_inject_pkg.sv | 15 +
 rtl/hr_flit_fifo.sv | 60 ++++++
 rtl/hr_local_inject.sv | 132 +++++++++++++
 3 files changed

// File: rtl/hr_local_inject_pkg.sv
// Shared flit layout and injection FSM encodings for the hierarchical-ring local inject NI.
package hr_local_inject_pkg;

  localparam int FLIT_W         = 144;
  localparam int FLIT_VALID_BIT = 12;
  localparam int FLIT_DST_LSB   = 0;
  localparam int FLIT_DST_W     = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OFFER   = 2'd1,
    STARVED = 2'd2
  } inj_state_e;

endpackage

// File: rtl/hr_flit_fifo.sv
// Flit FIFO with occupancy-derived full/empty; exposes the post-edge head so the
// consumer can register it with single-cycle latency.
module hr_flit_fifo
  import hr_local_inject_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = FLIT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             wr_data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH):0]   count_next_o,
  output logic [W-1:0]             head_next_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_i && !pop_i)      count_d = count_q + CNT_ONE;
    else if (!push_i && pop_i) count_d = count_q - CNT_ONE;
    // When nothing older survives this edge, the next head is the incoming word.
    if ((count_q == '0) || ((count_q == CNT_ONE) && pop_i)) head_next_o = wr_data_i;
    else                                                    head_next_o = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full_o       = (count_q == CNT_FULL);
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/hr_local_inject.sv
// Local-port injection NI: core valid/ready into a flit FIFO, registered offer to the node
// with ack-based retry and starvation flag. Optional counters under HR_NI_STATS_EN.
//
// state   | meaning
// IDLE    | FIFO empty, nothing offered
// OFFER   | head offered, waiting fewer than STARVE_MAX cycles
// STARVED | head un-acked for STARVE_MAX cycles, starve asserted
module hr_local_inject
  import hr_local_inject_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FLIT_W-1:0]      inj_flit,
  input  logic                   inj_valid,
  output logic                   inj_ready,
  output logic [FLIT_W-1:0]      port_local_o,
  input  logic                   portl_ack,
  output logic                   starve,
  output logic [$clog2(DEPTH):0] occupancy
`ifdef HR_NI_STATS_EN
  ,
  output logic [31:0]            stat_inj_cnt,
  output logic [31:0]            stat_retry_cnt
`endif
);

  localparam int WAIT_W = $clog2(STARVE_MAX) + 1;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  inj_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [FLIT_W-1:0] port_local_q, port_local_d;
  logic [FLIT_W-1:0] wr_data, head_next;
  logic [CNT_W-1:0]  count, count_next;
  logic              full, push, pop, offer_vld, last_one;

  assign offer_vld = port_local_q[FLIT_VALID_BIT];
  assign push      = inj_valid && !full;
  assign pop       = portl_ack && offer_vld;
  assign last_one  = (count == CNT_W'(1)) && !push;

  always_comb begin
    wr_data                 = inj_flit;
    wr_data[FLIT_VALID_BIT] = 1'b1;
  end

  hr_flit_fifo #(
    .DEPTH (DEPTH),
    .W     (FLIT_W)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .wr_data_i    (wr_data),
    .pop_i        (pop),
    .full_o       (full),
    .count_o      (count),
    .count_next_o (count_next),
    .head_next_o  (head_next)
  );

  assign port_local_d = (count_next != '0) ? head_next : '0;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      IDLE: begin
        wait_d = '0;
        if (push) state_d = OFFER;
      end
      OFFER: begin
        if (pop) begin
          wait_d = '0;
          if (last_one) state_d = IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          if (wait_d == WAIT_W'(STARVE_MAX)) state_d = STARVED;
        end
      end
      STARVED: begin
        // wait_q stays pinned at STARVE_MAX until the head finally goes.
        if (pop) begin
          wait_d  = '0;
          state_d = last_one ? IDLE : OFFER;
        end
      end
      default: begin
        state_d = IDLE;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      port_local_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      port_local_q <= port_local_d;
    end
  end

`ifdef HR_NI_STATS_EN
  logic [31:0] stat_inj_q, stat_retry_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_inj_q   <= '0;
      stat_retry_q <= '0;
    end else begin
      if (pop)                   stat_inj_q   <= stat_inj_q + 32'd1;
      if (offer_vld && !portl_ack) stat_retry_q <= stat_retry_q + 32'd1;
    end
  end

  assign stat_inj_cnt   = stat_inj_q;
  assign stat_retry_cnt = stat_retry_q;
`endif

  assign inj_ready    = !full;
  assign port_local_o = port_local_q;
  assign starve       = (state_q == STARVED);
  assign occupancy    = count;

endmodule
